// File: rtl/aes_req_scheduler_if.sv
// rtl/aes_req_scheduler_if.sv - requester, engine and rekey signal bundle for aes_req_scheduler
interface aes_req_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 128
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_decrypt;
    logic                    eng_in_valid;
    logic [DATA_W-1:0]       eng_in_data;
    logic                    eng_in_decrypt;
    logic                    eng_out_valid;
    logic [DATA_W-1:0]       eng_out_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rekey_req;
    logic                    rekey_ack;
    logic                    key_cfg_start;
    logic                    key_cfg_done;
    logic                    busy;
    logic                    tag_err;

    modport slave (
        input  req_valid, req_data, req_decrypt, eng_out_valid, eng_out_data,
               rekey_req, key_cfg_done,
        output req_ready, eng_in_valid, eng_in_data, eng_in_decrypt, rsp_valid,
               rsp_data, rekey_ack, key_cfg_start, busy, tag_err
    );

    modport master (
        output req_valid, req_data, req_decrypt, eng_out_valid, eng_out_data,
               rekey_req, key_cfg_done,
        input  req_ready, eng_in_valid, eng_in_data, eng_in_decrypt, rsp_valid,
               rsp_data, rekey_ack, key_cfg_start, busy, tag_err
    );
endinterface

// File: rtl/aes_req_scheduler.sv
// rtl/aes_req_scheduler.sv - round-robin issue, owner tagging and rekey sequencing for a shared AES pipeline
module aes_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 11,
    parameter int DATA_W  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_req_scheduler_if.slave bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {ST_ISSUE, ST_DRAIN, ST_CONFIG, ST_ACK} state_e;

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0] tag_v_q;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rekey_ack_q, key_cfg_start_q, tag_err_q;

    logic               grant;
    logic [IDW-1:0]     grant_id;
    logic               tag_out_v;
    logic [IDW-1:0]     tag_out_id;

    // Scanning from the far end lets the requester closest to rr_ptr overwrite the others.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        if (rst_n && state_q == ST_ISSUE && !bus.rekey_req) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                    grant    = 1'b1;
                    grant_id = IDW'((int'(rr_ptr_q) + k) % N_REQ);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready      = '0;
        bus.eng_in_data    = '0;
        bus.eng_in_decrypt = 1'b0;
        if (grant) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.eng_in_data         = bus.req_data[grant_id*DATA_W +: DATA_W];
            bus.eng_in_decrypt      = bus.req_decrypt[grant_id];
        end
    end

    assign tag_out_v  = tag_v_q[LATENCY-1];
    assign tag_out_id = tag_id_q[LATENCY-1];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (grant && !tag_out_v) begin
            in_flight_d = in_flight_q + 1'b1;
        end else if (!grant && tag_out_v) begin
            in_flight_d = in_flight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            in_flight_q <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            tag_v_q[0]  <= grant;
            tag_id_q[0] <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // A tag/engine disagreement never produces a response, only the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (tag_out_v && bus.eng_out_valid) begin
                rsp_valid_q[tag_out_id] <= 1'b1;
                rsp_data_q              <= bus.eng_out_data;
            end
            if (tag_out_v ^ bus.eng_out_valid) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_ISSUE;
            key_cfg_start_q <= 1'b0;
            rekey_ack_q     <= 1'b0;
        end else begin
            key_cfg_start_q <= 1'b0;
            rekey_ack_q     <= 1'b0;
            case (state_q)
                ST_ISSUE: begin
                    if (bus.rekey_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (in_flight_q == '0) begin
                        state_q         <= ST_CONFIG;
                        key_cfg_start_q <= 1'b1;
                    end
                end
                ST_CONFIG: begin
                    if (bus.key_cfg_done) begin
                        state_q     <= ST_ACK;
                        rekey_ack_q <= 1'b1;
                    end
                end
                ST_ACK:  state_q <= ST_ISSUE;
                default: state_q <= ST_ISSUE;
            endcase
        end
    end

    assign bus.eng_in_valid  = grant;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rekey_ack     = rekey_ack_q;
    assign bus.key_cfg_start = key_cfg_start_q;
    assign bus.tag_err       = tag_err_q;
    assign bus.busy          = (in_flight_q != '0) || (state_q != ST_ISSUE);
endmodule

// File: tb/tb_aes_req_scheduler.sv
// tb/tb_aes_req_scheduler.sv - randomized scenarios for aes_req_scheduler against a queue-based reference model
module tb_aes_req_scheduler;
    localparam int N = 4;
    localparam int L = 11;
    localparam int W = 128;
    localparam logic [W-1:0] KEY = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_req_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();
    aes_req_scheduler #(.N_REQ(N), .LATENCY(L), .DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [W-1:0] aes_stub(input logic [W-1:0] d, input logic dec);
        return dec ? ({d[63:0], d[127:64]} ^ KEY) : (d ^ ~KEY);
    endfunction

    // Stand-in engine: fixed L-cycle delay, not reset by rst_n, so stale blocks survive a reset.
    logic [L-1:0] pipe_v = '0;
    logic [W-1:0] pipe_d [L];
    logic         inject_v = 1'b0;
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[L-2:0], bus.eng_in_valid};
        pipe_d[0] <= aes_stub(bus.eng_in_data, bus.eng_in_decrypt);
        for (int i = 1; i < L; i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign bus.eng_out_valid = pipe_v[L-1] | inject_v;
    assign bus.eng_out_data  = pipe_d[L-1];

    typedef struct { int issue; int id; logic [W-1:0] data; } exp_t;
    exp_t exp_q[$];
    int   cyc = 0;
    int   m_ptr = 0;
    int   m_stage = 0;   // 0 issuing, 1 draining, 2 awaiting key controller, 3 acknowledging
    bit   m_cfg_pulse = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic m_reset();
        exp_q.delete();
        m_ptr = 0;
        m_stage = 0;
        m_cfg_pulse = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N * W / 32; i++) bus.req_data[i*32 +: 32] = $urandom();
        bus.req_decrypt = N'($urandom());
    endtask

    // Called at a falling edge: predicts and compares this cycle, advances the model, returns just after the rising edge.
    task automatic sb_step();
        int g, infl;
        logic [N-1:0] exp_ready, exp_rv;
        logic [W-1:0] exp_data, exp_rd;
        logic         exp_dec;
        g = -1;
        if (m_stage == 0 && !bus.rekey_req)
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_ready = '0; exp_data = '0; exp_dec = 1'b0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_data     = bus.req_data[g*W +: W];
            exp_dec      = bus.req_decrypt[g];
        end
        n_checks++;
        if (bus.req_ready !== exp_ready || bus.eng_in_valid !== (g >= 0) ||
            bus.eng_in_data !== exp_data || bus.eng_in_decrypt !== exp_dec) begin
            n_fail++;
            $display("FAIL issue cyc=%0d: ready=%b valid=%b dec=%b data=%h, expected ready=%b dec=%b data=%h",
                     cyc, bus.req_ready, bus.eng_in_valid, bus.eng_in_decrypt, bus.eng_in_data, exp_ready, exp_dec, exp_data);
        end
        exp_rv = '0; exp_rd = '0;
        if (exp_q.size() > 0 && exp_q[0].issue + L + 1 == cyc) begin
            exp_rv[exp_q[0].id] = 1'b1;
            exp_rd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (bus.rsp_valid !== exp_rv || (exp_rv != '0 && bus.rsp_data !== exp_rd)) begin
            n_fail++;
            $display("FAIL response cyc=%0d: rsp_valid=%b data=%h, expected rsp_valid=%b data=%h",
                     cyc, bus.rsp_valid, bus.rsp_data, exp_rv, exp_rd);
        end
        infl = 0;
        foreach (exp_q[i]) if (exp_q[i].issue + L + 1 > cyc) infl++;
        n_checks++;
        if (bus.key_cfg_start !== m_cfg_pulse || bus.rekey_ack !== (m_stage == 3) ||
            bus.busy !== (infl > 0 || m_stage != 0)) begin
            n_fail++;
            $display("FAIL control cyc=%0d: key_cfg_start=%b rekey_ack=%b busy=%b, expected %b %b %b",
                     cyc, bus.key_cfg_start, bus.rekey_ack, bus.busy, m_cfg_pulse, (m_stage == 3), (infl > 0 || m_stage != 0));
        end
        m_cfg_pulse = 1'b0;
        case (m_stage)
            0: if (bus.rekey_req) m_stage = 1;
            1: if (infl == 0) begin m_stage = 2; m_cfg_pulse = 1'b1; end
            2: if (bus.key_cfg_done) m_stage = 3;
            default: m_stage = 0;
        endcase
        if (g >= 0) begin
            exp_q.push_back('{cyc, g, aes_stub(exp_data, exp_dec)});
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sb_step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        rand_data();
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.eng_in_valid, bus.eng_in_data, bus.eng_in_decrypt, bus.rsp_valid, bus.rsp_data,
             bus.rekey_ack, bus.key_cfg_start, bus.busy, bus.tag_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b eng_v=%b rsp_v=%b ack=%b start=%b busy=%b tag_err=%b, all required 0",
                     bus.req_ready, bus.eng_in_valid, bus.rsp_valid, bus.rekey_ack, bus.key_cfg_start, bus.busy, bus.tag_err);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        m_reset();
        run_idle(2);
    endtask

    task automatic test_round_robin();
        bus.req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            @(negedge clk);
            n_checks++;
            if (bus.req_ready !== N'(1 << (i % N))) begin
                n_fail++;
                $display("FAIL rr_order step %0d: req_ready=%b, expected %b", i, bus.req_ready, N'(1 << (i % N)));
            end
            sb_step();
        end
        bus.req_valid = '0;
        run_idle(L + 3);
    endtask

    task automatic test_sparse();
        logic [N-1:0] pat [4];
        logic [N-1:0] want [4];
        pat  = '{4'b0100, 4'b0000, 4'b0010, 4'b1010};
        want = '{4'b0100, 4'b0000, 4'b0010, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = pat[i];
            rand_data();
            @(negedge clk);
            n_checks++;
            if (bus.req_ready !== want[i]) begin
                n_fail++;
                $display("FAIL sparse step %0d: req_ready=%b, expected %b", i, bus.req_ready, want[i]);
            end
            sb_step();
        end
        bus.req_valid = '0;
        run_idle(L + 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            bus.req_valid = N'($urandom());
            rand_data();
            @(negedge clk);
            sb_step();
        end
        bus.req_valid = '0;
        run_idle(L + 3);
    endtask

    task automatic test_rekey_load();
        int cfg_cyc = -1, ack_cyc = -1, resume = -1, stray = 0;
        bus.req_valid = '1;
        for (int i = 0; i < 80; i++) begin
            rand_data();
            bus.rekey_req    = (i >= 20 && ack_cyc < 0);
            bus.key_cfg_done = (cfg_cyc >= 0 && i == cfg_cyc + 5);
            @(negedge clk);
            if (bus.key_cfg_start === 1'b1 && cfg_cyc < 0) cfg_cyc = i;
            if (bus.rekey_ack === 1'b1 && ack_cyc < 0) ack_cyc = i;
            if (i >= 20 && bus.req_ready !== '0) begin
                if (ack_cyc >= 0 && i > ack_cyc && resume < 0) resume = i;
                else if (resume < 0) stray++;
            end
            sb_step();
            if (resume >= 0 && i >= resume + 1) break;
        end
        bus.rekey_req = 1'b0;
        bus.key_cfg_done = 1'b0;
        bus.req_valid = '0;
        n_checks++;
        if (cfg_cyc !== 19 + L + 2) begin
            n_fail++;
            $display("FAIL rekey_load_start: key_cfg_start at cycle %0d, expected %0d", cfg_cyc, 19 + L + 2);
        end
        n_checks++;
        if (ack_cyc < 0 || ack_cyc !== cfg_cyc + 6) begin
            n_fail++;
            $display("FAIL rekey_load_ack: rekey_ack at cycle %0d, expected %0d", ack_cyc, cfg_cyc + 6);
        end
        n_checks++;
        if (stray !== 0 || resume < 0 || resume !== ack_cyc + 1) begin
            n_fail++;
            $display("FAIL rekey_load_grants: %0d grants while rekeying, resume at %0d, expected 0 and %0d", stray, resume, ack_cyc + 1);
        end
        run_idle(L + 3);
    endtask

    task automatic test_rekey_idle();
        int cfg_cyc = -1, ack_cyc = -1;
        bus.key_cfg_done = 1'b1;
        @(negedge clk);
        sb_step();
        bus.key_cfg_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.rekey_ack !== 1'b0 || bus.busy !== 1'b0 || bus.key_cfg_start !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_done: rekey_ack=%b busy=%b key_cfg_start=%b, expected 0 0 0",
                         bus.rekey_ack, bus.busy, bus.key_cfg_start);
            end
            sb_step();
        end
        for (int i = 0; i < 20; i++) begin
            bus.rekey_req    = (ack_cyc < 0);
            bus.key_cfg_done = (cfg_cyc >= 0 && i == cfg_cyc + 3);
            @(negedge clk);
            if (bus.key_cfg_start === 1'b1 && cfg_cyc < 0) cfg_cyc = i;
            if (bus.rekey_ack === 1'b1 && ack_cyc < 0) ack_cyc = i;
            sb_step();
            if (ack_cyc >= 0 && i >= ack_cyc + 2) break;
        end
        bus.rekey_req = 1'b0;
        bus.key_cfg_done = 1'b0;
        n_checks++;
        if (cfg_cyc !== 2 || ack_cyc !== 6) begin
            n_fail++;
            $display("FAIL rekey_idle: key_cfg_start at %0d, rekey_ack at %0d, expected 2 and 6", cfg_cyc, ack_cyc);
        end
        run_idle(2);
    endtask

    task automatic test_tag_err();
        inject_v = 1'b1;
        @(negedge clk);
        sb_step();
        inject_v = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.tag_err !== 1'b1 || bus.rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL tag_err_set: tag_err=%b rsp_valid=%b, expected 1 and 0", bus.tag_err, bus.rsp_valid);
        end
        sb_step();
        run_idle(5);
        @(negedge clk);
        n_checks++;
        if (bus.tag_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tag_err_sticky: tag_err=%b, expected 1", bus.tag_err);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.tag_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_err_clear: tag_err=%b during reset, expected 0", bus.tag_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        run_idle(2);
    endtask

    task automatic test_async_reset();
        bus.req_valid = '1;
        repeat (5) begin
            rand_data();
            @(negedge clk);
            sb_step();
        end
        bus.req_valid = '0;
        run_idle(2);
        bus.req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.eng_in_valid, bus.eng_in_data, bus.rsp_valid, bus.rekey_ack,
             bus.key_cfg_start, bus.busy, bus.tag_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: ready=%b eng_v=%b rsp_v=%b busy=%b tag_err=%b, all required 0",
                     bus.req_ready, bus.eng_in_valid, bus.rsp_valid, bus.busy, bus.tag_err);
        end
        m_reset();
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_idle: busy=%b after release, expected 0", bus.busy);
        end
        sb_step();
        run_idle(L + 2);
        @(negedge clk);
        n_checks++;
        if (bus.tag_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_blocks: tag_err=%b after orphaned engine outputs, expected 1", bus.tag_err);
        end
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_decrypt  = '0;
        bus.rekey_req    = 1'b0;
        bus.key_cfg_done = 1'b0;
        test_reset();
        test_round_robin();
        test_sparse();
        test_random();
        test_rekey_load();
        test_rekey_idle();
        test_tag_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_req_scheduler.md
# aes_req_scheduler

Round-robin scheduler sharing one fully pipelined, fixed-latency AES round pipeline among N_REQ requesters. It issues at most one block per cycle into the pipeline and tracks the owner of every in-flight block in a tag shift register. Completed blocks are routed back to their owner. It also sequences rekeying: it stops issue, drains the pipeline, pulses the key controller and resumes only after the key controller completes.

## Interface
- N_REQ, default 4: number of requesters, 2..8
- LATENCY, default 11: cycles from eng_in_valid to the matching eng_out_valid, 1..16
- DATA_W, default 128: block width
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_ready  out  N_REQ  request accepted this cycle; one-hot or zero
- req_data  in  N_REQ*DATA_W  requester i block at bits [i*DATA_W +: DATA_W]
- req_decrypt  in  N_REQ  1 = decrypt, 0 = encrypt
- eng_in_valid  out  1  issue strobe to the pipeline
- eng_in_data  out  DATA_W  issued block
- eng_in_decrypt  out  1  direction of the issued block
- eng_out_valid  in  1  pipeline output strobe
- eng_out_data  in  DATA_W  pipeline output block
- rsp_valid  out  N_REQ  one-hot response strobe; no backpressure
- rsp_data  out  DATA_W  response block, shared by all requesters
- rekey_req  in  1  level request to change the key
- rekey_ack  out  1  one-cycle pulse when rekeying completes
- key_cfg_start  out  1  one-cycle pulse to the key controller
- key_cfg_done  in  1  one-cycle pulse from the key controller
- busy  out  1  any block in flight, or state not ISSUE
- tag_err  out  1  sticky; cleared only by reset

## Operation
- States: ISSUE, DRAIN, CONFIG, ACK.
- **ISSUE**
  - Grant goes to the lowest requester index at or after rr_ptr, wrapping, among those with req_valid=1.
  - On a grant: req_ready[g]=1, eng_in_valid=1, eng_in_data=req_data[g], eng_in_decrypt=req_decrypt[g], rr_ptr <= (g+1) mod N_REQ.
  - No requester valid: no grant; rr_ptr holds.
- **Rekey entry**
  - rekey_req=1 in ISSUE: no grant in that cycle; go to DRAIN.
  - rekey_req has priority over pending requests.
- **DRAIN**
  - No grants.
  - When in_flight == 0, go to CONFIG and pulse key_cfg_start for one cycle on entry.
  - If in_flight is already 0 in the cycle DRAIN is entered, move to CONFIG on the next cycle.
- **CONFIG**
  - No grants; wait for key_cfg_done.
  - key_cfg_done moves the state to ACK.
  - key_cfg_done received in any other state is ignored.
- **ACK**
  - rekey_ack=1 for one cycle; go to ISSUE.
  - If rekey_req is still high on return to ISSUE, a new rekey begins, i.e. a level held across ACK rekeys again. Requesters drop rekey_req on rekey_ack.
- **Tag tracking**
  - LATENCY-deep shift register of {valid, owner id}, shifted every cycle.
  - Stage 0 is loaded with {grant, g}.
  - in_flight is a counter: +1 on issue, -1 on tag-output valid; both in the same cycle leaves it unchanged.
- **Response routing**
  - rsp_valid[id]=1 and rsp_data=eng_out_data when the tag output valid and eng_out_valid are both 1.
- **Tag error**
  - Tag output valid XOR eng_out_valid sets tag_err.
  - On a mismatch no rsp_valid is asserted.
  - in_flight still decrements on tag valid.

## Timing
- **Reset values**
  - State ISSUE, rr_ptr=0, tags cleared, in_flight=0.
  - All outputs 0; rsp_data and eng_in_data also 0.
- **Issue path**
  - req_ready, eng_in_valid, eng_in_data and eng_in_decrypt are combinational from req_valid, state and rr_ptr.
  - Issue throughput is one block per cycle, back to back.
- **Response path**
  - rsp_valid and rsp_data are registered: rsp_valid appears one cycle after eng_out_valid.
  - Request-to-response latency is LATENCY+1 cycles.
- rekey_ack, key_cfg_start and tag_err are registered.
- Worst-case rekey time is LATENCY + 1 + key controller time + 1 cycles.
- Reset mid-operation clears all tags; in-flight results arriving after reset are flagged as tag_err if eng_out_valid is still asserted.
- Simultaneous issue and retire in one cycle is supported.
- rr_ptr wraps from N_REQ-1 to 0.

## Test plan
- **Round-robin fairness:** N_REQ=4, all four req_valid held for 8 cycles -> grants 0,1,2,3,0,1,2,3 in consecutive cycles; each rsp_valid[i] appears 12 cycles after its grant with matching data.
- **Sparse requests:** only req 2 valid, then req 1 -> grant 2, rr_ptr=3, next grant 1; no idle-cycle grants.
- **Rekey under load:** continuous traffic, rekey_req at cycle 20 -> no grants from cycle 20; key_cfg_start exactly when the last in-flight response retires; key_cfg_done 5 cycles later -> rekey_ack 1 cycle later; grants resume the cycle after.
- **Rekey while idle:** in_flight=0 -> key_cfg_start one cycle after DRAIN entry; a spurious key_cfg_done in ISSUE is ignored.
- **Tag error:** inject eng_out_valid with no block in flight -> tag_err=1, no rsp_valid, stays set until rst_n low.
- **Async reset mid-traffic:** assert rst_n low asynchronously with 5 blocks in flight -> all outputs 0 immediately, in_flight=0, state ISSUE after release.
